// File: rtl/lighting_actuator.sv
// lighting_actuator: steps lamp enables and shade position toward a latched
// target, one lamp bit and one shade level per step, every STEP_CYCLES clocks.
// Optional build macro: LIGHTING_ACTUATOR_RETARGET_EN (accept new targets mid-ramp).
module lighting_actuator #(
  parameter int STEP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] lightstate_in,
  input  logic [3:0]  wshade_in,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] lamp_out,
  output logic [3:0]  shade_pos,
  output logic        shade_up,
  output logic        shade_dn
);
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(STEP_CYCLES - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t        state, state_nx;
  logic [15:0]   tgt, tgt_nx, lamp_nx;
  logic [3:0]    shd, shd_nx, shade_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          done_nx, up_nx, dn_nx;
  // no-change load: done is deferred one edge after acceptance
  logic          pend, pend_nx;

  logic [15:0]   off_vec, on_vec, step_lamp;
  logic [3:0]    step_shade;

  // one step toward target: lowest pending turn-off first, else lowest turn-on
  always_comb begin
    off_vec    = lamp_out & ~tgt;
    on_vec     = ~lamp_out & tgt;
    step_lamp  = (off_vec != '0) ? (lamp_out & ~(off_vec & (~off_vec + 16'd1)))
                                 : (lamp_out | (on_vec & (~on_vec + 16'd1)));
    step_shade = shade_pos;
    if (shade_pos < shd)      step_shade = shade_pos + 4'd1;
    else if (shade_pos > shd) step_shade = shade_pos - 4'd1;
  end

  assign busy = (state == RAMP);
`ifdef LIGHTING_ACTUATOR_RETARGET_EN
  assign ready = 1'b1;
`else
  assign ready = !busy;
`endif

  // next-state and next-output logic
  always_comb begin
    state_nx = state;
    tgt_nx   = tgt;
    shd_nx   = shd;
    cnt_nx   = cnt;
    lamp_nx  = lamp_out;
    shade_nx = shade_pos;
    done_nx  = 1'b0;
    up_nx    = 1'b0;
    dn_nx    = 1'b0;
    pend_nx  = 1'b0;
    case (state)
      IDLE: begin
        done_nx = pend;
        if (load) begin
          tgt_nx = lightstate_in;
          shd_nx = wshade_in;
          if (lightstate_in == lamp_out && wshade_in == shade_pos) begin
            pend_nx = 1'b1;
          end else begin
            cnt_nx   = RELOAD;
            state_nx = RAMP;
          end
        end
      end
      RAMP: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else begin
          lamp_nx  = step_lamp;
          shade_nx = step_shade;
          up_nx    = (shade_pos < shd);
          dn_nx    = (shade_pos > shd);
          cnt_nx   = RELOAD;
          if (step_lamp == tgt && step_shade == shd) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
`ifdef LIGHTING_ACTUATOR_RETARGET_EN
        // a step on this edge still uses the old targets; new ones take over after
        if (load) begin
          tgt_nx = lightstate_in;
          shd_nx = wshade_in;
          done_nx = 1'b0;
          if (lightstate_in == lamp_nx && wshade_in == shade_nx) begin
            state_nx = IDLE;
            pend_nx  = 1'b1;
          end else begin
            state_nx = RAMP;
          end
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // state and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tgt       <= '0;
      shd       <= '0;
      cnt       <= '0;
      lamp_out  <= '0;
      shade_pos <= '0;
      done      <= 1'b0;
      shade_up  <= 1'b0;
      shade_dn  <= 1'b0;
      pend      <= 1'b0;
    end else begin
      state     <= state_nx;
      tgt       <= tgt_nx;
      shd       <= shd_nx;
      cnt       <= cnt_nx;
      lamp_out  <= lamp_nx;
      shade_pos <= shade_nx;
      done      <= done_nx;
      shade_up  <= up_nx;
      shade_dn  <= dn_nx;
      pend      <= pend_nx;
    end
  end
endmodule

// File: tb/tb_lighting_actuator.sv
// Directed bench for lighting_actuator: one instance at STEP_CYCLES=4, one at 1.
module tb_lighting_actuator;
  logic clk = 1'b0;
  logic rst_n;
  logic la, lb;
  logic [15:0] lta, ltb;
  logic [3:0]  sha, shb;
  logic ra, ba, da, ua, dna, rb, bb, db, ub, dnb;
  logic [15:0] lampa, lampb;
  logic [3:0]  posa, posb;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lighting_actuator #(.STEP_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(la), .lightstate_in(lta), .wshade_in(sha),
    .ready(ra), .busy(ba), .done(da), .lamp_out(lampa), .shade_pos(posa),
    .shade_up(ua), .shade_dn(dna));

  lighting_actuator #(.STEP_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(lb), .lightstate_in(ltb), .wshade_in(shb),
    .ready(rb), .busy(bb), .done(db), .lamp_out(lampb), .shade_pos(posb),
    .shade_up(ub), .shade_dn(dnb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one full step period on dut_a: quiet for 3 edges, then the step lands
  task automatic step4(input string tag, input logic [15:0] el, input logic [3:0] es,
                       input logic eu, input logic ed, input logic edn);
    repeat (3) tick();
    chk({tag, "_quiet"}, {29'd0, da, ua, dna}, 32'd0);
    tick();
    chk({tag, "_lamp"}, {16'd0, lampa}, {16'd0, el});
    chk({tag, "_shade"}, {28'd0, posa}, {28'd0, es});
    chk({tag, "_up"}, {31'd0, ua}, {31'd0, eu});
    chk({tag, "_dn"}, {31'd0, dna}, {31'd0, ed});
    chk({tag, "_done"}, {31'd0, da}, {31'd0, edn});
  endtask

  initial begin
    rst_n = 1'b0; la = 1'b0; lb = 1'b0;
    lta = '0; sha = '0; ltb = '0; shb = '0;
    tick(); tick();
    // reset values
    chk("rst_lamp", {16'd0, lampa}, 32'd0);
    chk("rst_shade", {28'd0, posa}, 32'd0);
    chk("rst_flags", {26'd0, ra, ba, da, ua, dna, 1'b0}, {26'd0, 6'b100000});
    rst_n = 1'b1;
    tick();

    // ramp 0x000F / shade 3 at cadence 4
    la = 1'b1; lta = 16'h000F; sha = 4'd3;
    tick();
    la = 1'b0;
    chk("t1_accept", {30'd0, ba, ra}, {30'd0, 2'b10});
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("t1_lamp_%0d", k), {16'd0, lampa}, (32'h1 << (k / 4)) - 32'd1);
      chk($sformatf("t1_shade_%0d", k), {28'd0, posa}, (k / 4 > 3) ? 32'd3 : 32'(k / 4));
      chk($sformatf("t1_up_%0d", k), {31'd0, ua}, {31'd0, (k % 4 == 0) && (k <= 12)});
      chk($sformatf("t1_done_%0d", k), {31'd0, da}, {31'd0, k == 16});
      chk($sformatf("t1_busy_%0d", k), {31'd0, ba}, {31'd0, k < 16});
    end

    // load equal to current outputs: done one edge later, no ramp
    la = 1'b1; lta = 16'h000F; sha = 4'd3;
    tick();
    la = 1'b0;
    chk("t3_e0", {30'd0, da, ba}, 32'd0);
    tick();
    chk("t3_done", {30'd0, da, ba}, {30'd0, 2'b10});
    chk("t3_lamp", {12'd0, lampa, posa}, {12'd0, 16'h000F, 4'd3});
    tick();
    chk("t3_after", {31'd0, da}, 32'd0);

    // set up 0x0003 / shade 5
    la = 1'b1; lta = 16'h0003; sha = 4'd5;
    tick();
    la = 1'b0;
    step4("s1", 16'h000B, 4'd4, 1'b1, 1'b0, 1'b0);
    step4("s2", 16'h0003, 4'd5, 1'b1, 1'b0, 1'b1);

    // turn-offs before turn-ons
    la = 1'b1; lta = 16'h0104; sha = 4'd4;
    tick();
    la = 1'b0;
    step4("t2a", 16'h0002, 4'd4, 1'b0, 1'b1, 1'b0);
    step4("t2b", 16'h0000, 4'd4, 1'b0, 1'b0, 1'b0);
    step4("t2c", 16'h0004, 4'd4, 1'b0, 1'b0, 1'b0);
    step4("t2d", 16'h0104, 4'd4, 1'b0, 1'b0, 1'b1);

    // second load during a ramp
    la = 1'b1; lta = 16'h00F0; sha = 4'd0;
    tick();
    la = 1'b0;
    tick();
`ifdef LIGHTING_ACTUATOR_RETARGET_EN
    chk("t4_ready", {31'd0, ra}, 32'd1);
`else
    chk("t4_ready", {31'd0, ra}, 32'd0);
`endif
    la = 1'b1; lta = 16'hFFFF; sha = 4'd15;
    tick();
    la = 1'b0;
    tick(); tick();
`ifdef LIGHTING_ACTUATOR_RETARGET_EN
    chk("t4r_s1", {12'd0, lampa, posa}, {12'd0, 16'h0105, 4'd5});
    begin
      int n = 0;
      while (!da && n < 80) begin tick(); n++; end
      chk("t4r_done_seen", {31'd0, da}, 32'd1);
      chk("t4r_steps", n, 32'd52);
      chk("t4r_final", {12'd0, lampa, posa}, {12'd0, 16'hFFFF, 4'd15});
    end
`else
    chk("t4_s1", {12'd0, lampa, posa}, {12'd0, 16'h0100, 4'd3});
    step4("t4b", 16'h0000, 4'd2, 1'b0, 1'b1, 1'b0);
    step4("t4c", 16'h0010, 4'd1, 1'b0, 1'b1, 1'b0);
    step4("t4d", 16'h0030, 4'd0, 1'b0, 1'b1, 1'b0);
    step4("t4e", 16'h0070, 4'd0, 1'b0, 1'b0, 1'b0);
    step4("t4f", 16'h00F0, 4'd0, 1'b0, 1'b0, 1'b1);
`endif

    // reset mid-ramp, load on the same edge must lose
    la = 1'b1; lta = 16'h00FF; sha = 4'd8;
    tick();
    la = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0; la = 1'b1; lta = 16'h0001; sha = 4'd1;
    tick();
    rst_n = 1'b1; la = 1'b0;
    chk("t5_lamp", {16'd0, lampa}, 32'd0);
    chk("t5_shade", {28'd0, posa}, 32'd0);
    chk("t5_flags", {27'd0, ra, ba, da, ua, dna}, {27'd0, 5'b10000});
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t5_nodone_%0d", k), {30'd0, da, ba}, 32'd0);
    end
    la = 1'b1; lta = 16'h0001; sha = 4'd1;
    tick();
    la = 1'b0;
    step4("t5r", 16'h0001, 4'd1, 1'b1, 1'b0, 1'b1);

    // cadence 1: one lamp per clock
    lb = 1'b1; ltb = 16'hFFFF; shb = 4'd15;
    tick();
    lb = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("t6_lamp_%0d", k), {16'd0, lampb}, ((32'h1 << k) - 32'd1) & 32'hFFFF);
      chk($sformatf("t6_shade_%0d", k), {28'd0, posb}, (k > 15) ? 32'd15 : 32'(k));
      chk($sformatf("t6_up_%0d", k), {31'd0, ub}, {31'd0, k <= 15});
      chk($sformatf("t6_done_%0d", k), {31'd0, db}, {31'd0, k == 16});
    end
    tick();
    chk("t6_idle", {30'd0, db, bb}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
